// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    IINC  = 4'd0,
    IADD  = 4'd1,
    ISUB  = 4'd2,
    IMUL  = 4'd3,
    IDIV  = 4'd4,
    IREM  = 4'd5,
    IAND  = 4'd6,
    IOR   = 4'd7,
    IXOR  = 4'd8,
    INEG  = 4'd9,
    ISHL  = 4'd10,
    ISHR  = 4'd11,
    IUSHR = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// done is asserted during the final step; quotient/remainder are valid
// while done is high (they show the result of the step in progress).
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic             busy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_sub;
  logic             fits;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When it fits the difference is below the divisor, so WIDTH bits suffice.
  always_comb begin
    r_sh    = {rem, quo[WIDTH-1]};
    r_sub   = r_sh[WIDTH-1:0] - dsr;
    fits    = (r_sh >= {1'b0, dsr});
    quo_nxt = {quo[WIDTH-2:0], fits};
    rem_nxt = fits ? r_sub : r_sh[WIDTH-1:0];
  end

  assign done      = busy && (cnt == LAST_STEP);
  assign quotient  = quo_nxt;
  assign remainder = rem_nxt;

  // Load on start, then iterate WIDTH steps and drop busy on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      dsr  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      quo  <= dividend;
      rem  <= '0;
      dsr  <= divisor;
    end else if (busy) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == LAST_STEP) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential integer ALU with valid/ready handshakes on both sides.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | waiting for a request (in_ready high)
//   ST_MUL  | shift-add multiply, one partial product per clock
//   ST_DIV  | restoring divide running in alu_divider
//   ST_DONE | result held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_select,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero,
  output logic             illegal_op
);
  localparam logic [SHW:0] LAST_STEP = (SHW+1)'(WIDTH - 1);

  state_e             state;
  state_e             state_nxt;
  op_e                op_in;
  logic               ready_en;
  logic               accept;
  logic               b_zero;
  logic               div_start;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sc_lo;
  logic               sc_dbz;
  logic               sc_ill;
  logic [SHW:0]       cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   p_hi;
  logic [WIDTH-1:0]   p_lo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod;
  logic [2*WIDTH-1:0] mul_fix;
  logic               neg_res;
  logic               neg_rem;
  logic               is_rem;
  logic               div_done;
  logic [WIDTH-1:0]   div_q;
  logic [WIDTH-1:0]   div_r;
  logic [WIDTH-1:0]   div_fix;

  assign op_in     = op_e'(op_select);
  assign in_ready  = ready_en && (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign b_zero    = (operand_b == '0);
  assign div_start = accept && ((op_in == IDIV) || (op_in == IREM)) && !b_zero;
  assign a_mag     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign b_mag     = operand_b[WIDTH-1] ? -operand_b : operand_b;
  assign shamt     = operand_b[SHW-1:0];

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Single-cycle results, also the zero-divisor and illegal-opcode outcomes.
  always_comb begin
    sc_lo  = '0;
    sc_dbz = 1'b0;
    sc_ill = 1'b0;
    case (op_in)
      IINC:       sc_lo = operand_a + WIDTH'(1);
      IADD:       sc_lo = operand_a + operand_b;
      ISUB:       sc_lo = operand_a - operand_b;
      IAND:       sc_lo = operand_a & operand_b;
      IOR:        sc_lo = operand_a | operand_b;
      IXOR:       sc_lo = operand_a ^ operand_b;
      INEG:       sc_lo = ~operand_a;
      ISHL:       sc_lo = operand_a << shamt;
      ISHR:       sc_lo = $unsigned($signed(operand_a) >>> shamt);
      IUSHR:      sc_lo = operand_a >> shamt;
      IDIV, IREM: sc_dbz = b_zero;
      IMUL:       sc_lo = '0;
      default:    sc_ill = 1'b1;
    endcase
  end

  // Multiply step on magnitudes (multiplier in p_lo shifts out as product
  // fills in) and the sign fixes applied when the last step completes.
  always_comb begin
    mul_sum  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);
    mul_prod = {mul_sum, p_lo[WIDTH-1:1]};
    mul_fix  = neg_res ? -mul_prod : mul_prod;
    if (is_rem) div_fix = neg_rem ? -div_r : div_r;
    else        div_fix = neg_res ? -div_q : div_q;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_in == IMUL) state_nxt = ST_MUL;
          else if (div_start) state_nxt = ST_DIV;
          else state_nxt = ST_DONE;
        end
      end
      ST_MUL:  if (cnt == LAST_STEP) state_nxt = ST_DONE;
      ST_DIV:  if (div_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Keeps in_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Operand capture, multiply iteration and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mcand       <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      is_rem      <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt         <= '0;
            mcand       <= a_mag;
            p_hi        <= '0;
            p_lo        <= b_mag;
            neg_res     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            neg_rem     <= operand_a[WIDTH-1];
            is_rem      <= (op_in == IREM);
            result_lo   <= sc_lo;
            result_hi   <= '0;
            div_by_zero <= sc_dbz;
            illegal_op  <= sc_ill;
          end
        end
        ST_MUL: begin
          p_hi <= mul_prod[2*WIDTH-1:WIDTH];
          p_lo <= mul_prod[WIDTH-1:0];
          cnt  <= cnt + (SHW+1)'(1);
          if (cnt == LAST_STEP) begin
            result_hi <= mul_fix[2*WIDTH-1:WIDTH];
            result_lo <= mul_fix[WIDTH-1:0];
          end
        end
        ST_DIV: begin
          if (div_done) result_lo <= div_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at WIDTH=32.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op_select = 4'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] OP_INC = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4, OP_REM = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8, OP_NEG = 4'd9, OP_SHL = 4'd10, OP_SHR = 4'd11;
  localparam logic [3:0] OP_USHR = 4'd12;

  alu_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_select   (op_select),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo, input logic [31:0] hi,
                     input logic dbz, input logic ill, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.dbz = dbz; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; leaves out_ready low.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready stayed low for op %0h", op);
    end
    op_select = op;
    operand_a = a;
    operand_b = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: no out_valid for op %0h", op);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("valid_drop", {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int  lat;
    logic seen;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result_lo", {32'd0, result_lo}, 64'd0);
    chk("rst_result_hi", {32'd0, result_hi}, 64'd0);
    chk("rst_flags", {62'd0, div_by_zero, illegal_op}, 64'd0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1 chk("ready_after_edge", {63'd0, in_ready}, 64'd1);

    //   op       a             b             lo            hi            dbz   ill  lat
    add(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b0, 1);
    add(OP_INC,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h0,        1'b0, 1'b0, 1);
    add(OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1);
    add(OP_AND,  32'hF0F0FF00, 32'h0FF00FF0, 32'h00F00F00, 32'h0,        1'b0, 1'b0, 1);
    add(OP_OR,   32'hF0F0FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0,        1'b0, 1'b0, 1);
    add(OP_XOR,  32'hF0F0FF00, 32'h0FF00FF0, 32'hFF00F0F0, 32'h0,        1'b0, 1'b0, 1);
    add(OP_NEG,  32'h0F0F0F0F, 32'h00000000, 32'hF0F0F0F0, 32'h0,        1'b0, 1'b0, 1);
    add(OP_SHL,  32'h00000001, 32'h0000001F, 32'h80000000, 32'h0,        1'b0, 1'b0, 1);
    add(OP_SHL,  32'h00000003, 32'h00000020, 32'h00000003, 32'h0,        1'b0, 1'b0, 1);
    add(OP_SHR,  32'h80000000, 32'd33,       32'hC0000000, 32'h0,        1'b0, 1'b0, 1);
    add(OP_USHR, 32'h80000000, 32'd33,       32'h40000000, 32'h0,        1'b0, 1'b0, 1);
    add(OP_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
    add(OP_MUL,  32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 1'b0, 33);
    add(OP_MUL,  32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000000, 1'b0, 1'b0, 33);
    add(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 33);
    add(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'h0,        1'b0, 1'b0, 33);
    add(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 33);
    add(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b0, 1'b0, 33);
    add(OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b0, 1'b0, 33);
    add(OP_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'h0,        1'b0, 1'b0, 33);
    add(OP_REM,  32'd100,      32'hFFFFFFF9, 32'h00000002, 32'h0,        1'b0, 1'b0, 33);
    add(OP_DIV,  32'd5,        32'd10,       32'h00000000, 32'h0,        1'b0, 1'b0, 33);
    add(OP_REM,  32'd5,        32'd10,       32'h00000005, 32'h0,        1'b0, 1'b0, 33);
    add(OP_REM,  32'd1234,     32'd0,        32'h00000000, 32'h0,        1'b1, 1'b0, 1);
    add(OP_DIV,  32'hFFFFFFFF, 32'd0,        32'h00000000, 32'h0,        1'b1, 1'b0, 1);
    add(4'hF,    32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0,        1'b0, 1'b1, 1);
    add(4'hD,    32'h00000001, 32'h00000001, 32'h00000000, 32'h0,        1'b0, 1'b1, 1);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_lo", i), {32'd0, result_lo}, {32'd0, vecs[i].lo});
      chk($sformatf("v%0d_hi", i), {32'd0, result_hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_dbz", i), {63'd0, div_by_zero}, {63'd0, vecs[i].dbz});
      chk($sformatf("v%0d_ill", i), {63'd0, illegal_op}, {63'd0, vecs[i].ill});
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      release_out();
    end

    // Result held with out_ready low; a competing request must be ignored.
    issue(OP_ADD, 32'd5, 32'd6, lat);
    op_select = OP_SUB;
    operand_a = 32'd1;
    operand_b = 32'd9;
    in_valid  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_lo", {32'd0, result_lo}, 64'd11);
      chk("hold_hi", {32'd0, result_hi}, 64'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("ready_after_hold", {63'd0, in_ready}, 64'd1);

    // Reset in the middle of a multiply.
    issue(OP_INC, 32'd41, 32'd0, lat);
    release_out();
    @(negedge clk);
    op_select = OP_MUL;
    operand_a = 32'hFFFFFFFD;
    operand_b = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst_lo", {32'd0, result_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", {63'd0, seen}, 64'd0);
    chk("midrst_idle", {63'd0, in_ready}, 64'd1);
    issue(OP_MUL, 32'd6, 32'd7, lat);
    chk("post_rst_lo", {32'd0, result_lo}, 64'd42);
    chk("post_rst_hi", {32'd0, result_hi}, 64'd0);
    chk("post_rst_lat", 64'(lat), 64'd33);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
